// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller: pointers, status flags, sticky error flags and a
// registered, valid-qualified read stage in front of an external dual-port memory.
module sync_fifo_ctrl #(
   parameter int unsigned DATASIZE = 8,
   parameter int unsigned ADDRSIZE = 4,
   parameter int unsigned AF_LEVEL = 14,
   parameter int unsigned AE_LEVEL = 2
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_clr,
   input  logic                i_w_req,
   input  logic                i_r_req,
   input  logic [DATASIZE-1:0] i_mem_rdata,
   output logic [ADDRSIZE-1:0] o_mem_waddr,
   output logic [ADDRSIZE-1:0] o_mem_raddr,
   output logic                o_mem_w_en,
   output logic                o_mem_wfull_flag,
   output logic                o_full,
   output logic                o_empty,
   output logic                o_almost_full,
   output logic                o_almost_empty,
   output logic [ADDRSIZE:0]   o_count,
   output logic                o_overflow,
   output logic                o_underflow,
   output logic [DATASIZE-1:0] o_rdata,
   output logic                o_rvalid
);

   localparam logic [ADDRSIZE:0] AF_THR = (ADDRSIZE+1)'(AF_LEVEL);
   localparam logic [ADDRSIZE:0] AE_THR = (ADDRSIZE+1)'(AE_LEVEL);
   localparam logic [ADDRSIZE:0] ONE    = (ADDRSIZE+1)'(1);

   logic [ADDRSIZE:0]   wptr;
   logic [ADDRSIZE:0]   rptr;
   logic [ADDRSIZE:0]   count;
   logic                full;
   logic                empty;
   logic                w_acc;
   logic                r_acc;
   logic                overflow;
   logic                underflow;
   logic [DATASIZE-1:0] rdata;
   logic                rvalid;

   // Extra pointer MSB distinguishes full from empty when the low bits match.
   always_comb begin
      empty = (wptr == rptr);
      full  = (wptr[ADDRSIZE] != rptr[ADDRSIZE]) &&
              (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]);
      count = wptr - rptr;
      w_acc = i_w_req & ~full  & ~i_clr;
      r_acc = i_r_req & ~empty & ~i_clr;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         wptr      <= '0;
         rptr      <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         rdata     <= '0;
         rvalid    <= 1'b0;
      end else begin
         if (w_acc) wptr <= wptr + ONE;
         if (r_acc) begin
            rptr  <= rptr + ONE;
            rdata <= i_mem_rdata;
         end
         rvalid <= r_acc;
         if (i_w_req && full)  overflow  <= 1'b1;
         if (i_r_req && empty) underflow <= 1'b1;
      end
   end

   always_comb begin
      o_mem_waddr      = wptr[ADDRSIZE-1:0];
      o_mem_raddr      = rptr[ADDRSIZE-1:0];
      o_mem_w_en       = w_acc;
      o_mem_wfull_flag = full;
      o_full           = full;
      o_empty          = empty;
      o_almost_full    = (count >= AF_THR);
      o_almost_empty   = (count <= AE_THR);
      o_count          = count;
      o_overflow       = overflow;
      o_underflow      = underflow;
      o_rdata          = rdata;
      o_rvalid         = rvalid;
   end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: directed boundary scenarios plus randomized traffic,
// checked against a queue-based FIFO model.
module tb_sync_fifo_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;
   localparam int AF    = 14;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          rst, clr, w_req, r_req;
   logic [DW-1:0] wdata;
   logic [DW-1:0] mem_rdata;
   logic [AW-1:0] mem_waddr, mem_raddr;
   logic          mem_w_en, mem_wfull_flag;
   logic          full, empty, almost_full, almost_empty;
   logic [AW:0]   count;
   logic          overflow, underflow;
   logic [DW-1:0] rdata;
   logic          rvalid;

   logic [DW-1:0] mem [DEPTH];

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [DW-1:0] q[$];
   bit            m_ovf, m_unf, m_rvalid;
   logic [DW-1:0] m_rdata;
   int            wr_total, rd_total;

   always #5 clk = ~clk;

   sync_fifo_ctrl #(
      .DATASIZE(DW), .ADDRSIZE(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_w_req(w_req), .i_r_req(r_req),
      .i_mem_rdata(mem_rdata), .o_mem_waddr(mem_waddr), .o_mem_raddr(mem_raddr),
      .o_mem_w_en(mem_w_en), .o_mem_wfull_flag(mem_wfull_flag), .o_full(full),
      .o_empty(empty), .o_almost_full(almost_full), .o_almost_empty(almost_empty),
      .o_count(count), .o_overflow(overflow), .o_underflow(underflow),
      .o_rdata(rdata), .o_rvalid(rvalid)
   );

   // memory instance as seen by the controller: write gated by enable and full
   always @(posedge clk)
      if (mem_w_en && !mem_wfull_flag) mem[mem_waddr] <= wdata;
   assign mem_rdata = mem[mem_raddr];

   task automatic check_eq(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf = 0; m_unf = 0; m_rvalid = 0; m_rdata = '0;
      wr_total = 0; rd_total = 0;
   endtask

   task automatic check_state();
      check_eq("count",        int'(count),        q.size());
      check_eq("empty",        int'(empty),        int'(q.size() == 0));
      check_eq("full",         int'(full),         int'(q.size() == DEPTH));
      check_eq("almost_full",  int'(almost_full),  int'(q.size() >= AF));
      check_eq("almost_empty", int'(almost_empty), int'(q.size() <= AE));
      check_eq("overflow",     int'(overflow),     int'(m_ovf));
      check_eq("underflow",    int'(underflow),    int'(m_unf));
      check_eq("rvalid",       int'(rvalid),       int'(m_rvalid));
      check_eq("rdata",        int'(rdata),        int'(m_rdata));
      check_eq("waddr",        int'(mem_waddr),    wr_total % DEPTH);
      check_eq("raddr",        int'(mem_raddr),    rd_total % DEPTH);
   endtask

   // One clock: drive at negedge, check combinational gates, advance model at posedge.
   task automatic cycle(input bit w, input bit r, input bit c, input bit rs,
                        input logic [DW-1:0] d);
      bit is_full, is_empty, wa, ra;
      @(negedge clk);
      w_req = w; r_req = r; clr = c; rst = rs; wdata = d;
      is_full  = (q.size() == DEPTH);
      is_empty = (q.size() == 0);
      #1;
      check_eq("mem_w_en",   int'(mem_w_en),       int'(w && !is_full && !c));
      check_eq("wfull_flag", int'(mem_wfull_flag), int'(is_full));
      @(posedge clk);
      if (rs || c) begin
         model_reset();
      end else begin
         wa = w && !is_full;
         ra = r && !is_empty;
         if (w && is_full)  m_ovf = 1;
         if (r && is_empty) m_unf = 1;
         m_rvalid = ra;
         if (ra) begin
            m_rdata = q.pop_front();
            rd_total++;
         end
         if (wa) begin
            q.push_back(d);
            wr_total++;
         end
      end
      #1;
      check_state();
   endtask

   initial begin
      int c0;
      logic [DW-1:0] d;
      rst = 1; clr = 0; w_req = 0; r_req = 0; wdata = '0;
      model_reset();
      cycle(0, 0, 0, 1, 8'h00);
      cycle(1, 0, 0, 1, 8'h33);   // w_en follows w_req during reset

      // fill to full, then one overflow attempt
      for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 0, 8'(i));
      cycle(1, 0, 0, 0, 8'hEE);
      // drain, then one underflow attempt
      for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 0, 8'h00);
      cycle(0, 1, 0, 0, 8'h00);
      cycle(0, 0, 0, 0, 8'h00);

      // steady simultaneous traffic at count 5, pointers wrap
      cycle(0, 0, 1, 0, 8'h00);
      for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 8'($urandom));
      for (int i = 0; i < 40; i++) cycle(1, 1, 0, 0, 8'($urandom));

      // full with both requests, then empty with both requests
      for (int i = 0; i < DEPTH - 5; i++) cycle(1, 0, 0, 0, 8'($urandom));
      cycle(1, 1, 0, 0, 8'h77);
      cycle(0, 0, 1, 0, 8'h00);
      cycle(1, 1, 0, 0, 8'h5C);
      cycle(0, 1, 0, 0, 8'h00);

      // flush at count 9 with both requests
      for (int i = 0; i < 9; i++) cycle(1, 0, 0, 0, 8'($urandom));
      cycle(1, 1, 1, 0, 8'hFF);
      cycle(0, 0, 0, 0, 8'h00);

      // reset mid-stream at count 7, then round-trip 0xA5
      for (int i = 0; i < 7; i++) cycle(1, 0, 0, 0, 8'($urandom));
      cycle(1, 1, 0, 1, 8'h11);
      cycle(1, 0, 0, 0, 8'hA5);
      cycle(0, 1, 0, 0, 8'h00);
      check_eq("a5_roundtrip", int'(rdata), 8'hA5);
      cycle(0, 0, 0, 0, 8'h00);

      // randomized traffic with shifting write/read bias
      for (int seg = 0; seg < 12; seg++) begin
         int wp, rp;
         wp = (seg % 3 == 0) ? 80 : (seg % 3 == 1) ? 25 : 55;
         rp = (seg % 3 == 0) ? 25 : (seg % 3 == 1) ? 80 : 55;
         for (int i = 0; i < 150; i++) begin
            c0 = int'($urandom_range(0, 999));
            d  = 8'($urandom);
            cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                  c0 < 10, c0 >= 10 && c0 < 15, d);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
